// File: rtl/eth_rgmii_tx.sv
// rtl/eth_rgmii_tx.sv - RGMII Ethernet transmitter: preamble, header, payload, FCS, inter-frame gap
// Optional 802.1Q tag insertion is enabled by defining ETH_TX_VLAN_EN.

module eth_crc32_byte (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic fb;

  // Reflected CRC-32, data consumed LSB first.
  always_comb begin
    crc_out = crc_in;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb = crc_out[0] ^ data[i];
      crc_out = {1'b0, crc_out[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0000_0000);
    end
  end
endmodule

module eth_rgmii_tx #(
  parameter int          PAYLOAD_LEN = 200,
  parameter int          IFG         = 12,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter logic [15:0] VLAN_TCI    = 16'h0001
) (
  input  logic       clk125,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       busy,
  output logic       underrun,
  output logic       txctl,
  output logic [3:0] txd
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_FCS  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

`ifdef ETH_TX_VLAN_EN
  localparam int HDR_LEN = 18;
  localparam logic [HDR_LEN*8-1:0] HDR_BYTES = {DST_MAC, SRC_MAC, 8'h81, 8'h00, VLAN_TCI, ETHERTYPE};
`else
  localparam int HDR_LEN = 14;
  localparam logic [HDR_LEN*8-1:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
  logic unused_tci;
  assign unused_tci = ^VLAN_TCI;
`endif

  logic [2:0]           state;
  logic [2:0]           state_after;
  logic [10:0]          cnt;
  logic                 seg_last;
  logic [31:0]          crc;
  logic [31:0]          crc_nxt;
  logic [31:0]          fcs_word;
  logic                 under_q;
  logic                 armed;
  logic [HDR_LEN*8-1:0] hdr_sh;
  logic [7:0]           byte_nxt;
  logic                 ctl_nxt;
  logic [7:0]           byte1;
  logic [7:0]           byte2;
  logic                 ctl1;
  logic                 ctl2;

  always_comb begin
    seg_last    = 1'b0;
    state_after = S_IDLE;
    case (state)
      S_PRE: begin seg_last = (cnt == 11'd7);                     state_after = S_HDR; end
      S_HDR: begin seg_last = (cnt == 11'(HDR_LEN - 1));          state_after = S_PAY; end
      S_PAY: begin seg_last = (cnt == 11'(PAYLOAD_LEN - 1));      state_after = S_FCS; end
      S_FCS: begin seg_last = (cnt == 11'd3);                     state_after = S_GAP; end
      S_GAP: begin seg_last = (cnt == 11'(IFG - 1));              state_after = S_IDLE; end
      default: begin seg_last = 1'b0;                             state_after = S_IDLE; end
    endcase
  end

  // A starved frame keeps its raw CRC so the receiver sees a bad FCS.
  assign fcs_word = under_q ? crc : ~crc;
  assign hdr_sh   = HDR_BYTES << {cnt[4:0], 3'b000};

  always_comb begin
    byte_nxt = 8'h00;
    ctl_nxt  = 1'b0;
    case (state)
      S_PRE: begin ctl_nxt = 1'b1; byte_nxt = (cnt == 11'd7) ? 8'hD5 : 8'h55; end
      S_HDR: begin ctl_nxt = 1'b1; byte_nxt = hdr_sh[HDR_LEN*8-1 -: 8]; end
      S_PAY: begin ctl_nxt = 1'b1; byte_nxt = s_valid ? s_data : 8'h00; end
      S_FCS: begin ctl_nxt = 1'b1; byte_nxt = fcs_word[{cnt[1:0], 3'b000} +: 8]; end
      default: begin ctl_nxt = 1'b0; byte_nxt = 8'h00; end
    endcase
  end

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (byte_nxt),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      crc     <= 32'hFFFF_FFFF;
      under_q <= 1'b0;
      armed   <= 1'b0;
      byte1   <= 8'h00;
      ctl1    <= 1'b0;
      byte2   <= 8'h00;
      ctl2    <= 1'b0;
    end else begin
      armed <= 1'b1;
      byte1 <= byte_nxt;
      ctl1  <= ctl_nxt;
      byte2 <= byte1;
      ctl2  <= ctl1;
      if (state == S_HDR || state == S_PAY) crc <= crc_nxt;
      if (state == S_PAY && !s_valid) under_q <= 1'b1;
      if (state == S_IDLE) begin
        cnt <= '0;
        // armed masks the first edge after reset release
        if (start && armed) begin
          state   <= S_PRE;
          crc     <= 32'hFFFF_FFFF;
          under_q <= 1'b0;
        end
      end else if (seg_last) begin
        cnt   <= '0;
        state <= state_after;
      end else begin
        cnt <= cnt + 11'd1;
      end
    end
  end

  assign s_ready  = (state == S_PAY);
  assign busy     = (state != S_IDLE);
  assign underrun = under_q;
  assign txctl    = ctl2;
  assign txd      = clk125 ? byte2[3:0] : byte2[7:4];

endmodule

// File: tb/tb_eth_rgmii_tx.sv
// tb/tb_eth_rgmii_tx.sv - directed table-driven bench for eth_rgmii_tx
// Follows ETH_TX_VLAN_EN for header layout and frame length.
module tb_eth_rgmii_tx;
  localparam int          PLEN  = 46;
  localparam int          GAP   = 12;
  localparam logic [47:0] DST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC   = 48'h0200_0000_0001;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam logic [15:0] TCI   = 16'h0064;
`ifdef ETH_TX_VLAN_EN
  localparam int HLEN   = 18;
  localparam int HI_LEN = 76;
`else
  localparam int HLEN   = 14;
  localparam int HI_LEN = 72;
`endif

  logic       clk125 = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b1;
  logic       s_ready;
  logic       busy;
  logic       underrun;
  logic       txctl;
  logic [3:0] txd;

  eth_rgmii_tx #(
    .PAYLOAD_LEN (PLEN),
    .IFG         (GAP),
    .DST_MAC     (DST),
    .SRC_MAC     (SRC),
    .ETHERTYPE   (ETYPE),
    .VLAN_TCI    (TCI)
  ) dut (
    .clk125   (clk125),
    .rst_n    (rst_n),
    .start    (start),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .busy     (busy),
    .underrun (underrun),
    .txctl    (txctl),
    .txd      (txd)
  );

  always #4 clk125 = ~clk125;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    int         drop;
    int         exp_hi;
    logic       exp_und;
  } vec_t;

  vec_t       tbl[5];
  int         n_tests = 0;
  int         n_fail = 0;
  int         pay_k = 0;
  int         drop_at = -1;
  logic [7:0] pay_base = 8'h00;
  logic [7:0] pay_step = 8'h01;
  logic [7:0] smp_byte;
  logic       smp_ctl;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] e[$],
                                    input int from, input int n);
    for (int i = from; i < from + n; i++)
      if (i >= a.size() || i >= e.size() || a[i] !== e[i]) return i;
    return -1;
  endfunction

  // One byte-time: low nibble in the high phase, high nibble in the low phase,
  // then present the next payload byte if the DUT is consuming.
  task automatic cycle_step();
    logic [3:0] lo;
    @(posedge clk125); #1;
    lo = txd;
    smp_ctl = txctl;
    @(negedge clk125); #1;
    smp_byte = {txd, lo};
    if (s_ready) begin
      s_data  = pay_base + pay_step * 8'(pay_k);
      s_valid = (pay_k != drop_at);
      pay_k++;
    end
  endtask

  task automatic build_expected(input logic [7:0] base, input logic [7:0] step,
                                input int drop, input logic und);
    logic [47:0] d;
    logic [47:0] s;
    logic [15:0] e;
    logic [15:0] t;
    logic [31:0] c;
    logic [31:0] f;
    logic [7:0]  b;
    d = DST; s = SRC; e = ETYPE; t = TCI;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_q.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
`ifdef ETH_TX_VLAN_EN
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h00);
    exp_q.push_back(t[15:8]);
    exp_q.push_back(t[7:0]);
`endif
    exp_q.push_back(e[15:8]);
    exp_q.push_back(e[7:0]);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
    for (int k = 0; k < PLEN; k++) begin
      b = (k == drop) ? 8'h00 : base + step * 8'(k);
      exp_q.push_back(b);
      c = crc_upd(c, b);
    end
    f = und ? c : ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
  endtask

  task automatic run_frame(input int r);
    logic [7:0]  got[$];
    int          first_hi;
    int          lows;
    logic [31:0] c;
    string       p;
    first_hi = -1;
    lows = 0;
    p = $sformatf("r%0d_", r);
    build_expected(tbl[r].base, tbl[r].step, tbl[r].drop, tbl[r].exp_und);
    pay_base = tbl[r].base;
    pay_step = tbl[r].step;
    drop_at  = tbl[r].drop;
    pay_k    = 0;
    start    = 1'b1;
    for (int j = 0; j < 400; j++) begin
      cycle_step();
      if (j == 0) start = 1'b0;
      if (smp_ctl) begin
        if (first_hi < 0) first_hi = j;
        got.push_back(smp_byte);
      end else if (first_hi >= 0) begin
        lows++;
        if (lows == GAP + 2) break;
      end
    end
    check({p, "latency"}, first_hi, 2);
    check({p, "txctl_high_cycles"}, got.size(), tbl[r].exp_hi);
    check({p, "preamble_bad_idx"}, first_diff(got, exp_q, 0, 8), -1);
    check({p, "header_bad_idx"}, first_diff(got, exp_q, 8, HLEN), -1);
    check({p, "payload_bad_idx"}, first_diff(got, exp_q, 8 + HLEN, PLEN), -1);
    check({p, "fcs_bad_idx"}, first_diff(got, exp_q, 8 + HLEN + PLEN, 4), -1);
    check({p, "gap_low_cycles"}, lows, GAP + 2);
    check({p, "underrun"}, int'(underrun), int'(tbl[r].exp_und));
    if (!tbl[r].exp_und) begin
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < got.size(); i++) c = crc_upd(c, got[i]);
      check({p, "crc_residue"}, c, 32'hDEBB_20E3);
    end
  endtask

  initial begin
    int ph;
    int hi1;
    int lo;
    int hi2;
    tbl[0] = '{8'h00, 8'h01, -1, HI_LEN, 1'b0};
    tbl[1] = '{8'hA5, 8'h3B, 10, HI_LEN, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, -1, HI_LEN, 1'b0};
    tbl[3] = '{8'h5A, 8'h00, PLEN - 1, HI_LEN, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 0, HI_LEN, 1'b1};

    // Reset with start already high: nothing may leave IDLE.
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) cycle_step();
    check("rst_txctl", int'(smp_ctl), 0);
    check("rst_txd", int'(smp_byte), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_underrun", int'(underrun), 0);

    rst_n = 1'b1;
    pay_base = 8'h10; pay_step = 8'h03; drop_at = -1; pay_k = 0;
    cycle_step();
    check("start_ignored_first_edge", int'(busy), 0);
    cycle_step();
    check("start_taken_second_edge", int'(busy), 1);

    // Start held high: two back-to-back frames.
    ph = 0; hi1 = 0; lo = 0; hi2 = 0;
    for (int j = 0; j < 600 && ph != 4; j++) begin
      cycle_step();
      case (ph)
        0: if (smp_ctl) begin hi1 = 1; ph = 1; end
        1: if (smp_ctl) hi1++; else begin lo = 1; ph = 2; end
        2: if (!smp_ctl) lo++; else begin hi2 = 1; ph = 3; start = 1'b0; end
        3: if (smp_ctl) hi2++; else ph = 4;
        default: ph = 4;
      endcase
    end
    start = 1'b0;
    check("b2b_frame1_high", hi1, HI_LEN);
    check("b2b_low_between", lo, GAP + 1);
    check("b2b_frame2_high", hi2, HI_LEN);
    for (int j = 0; j < 100 && busy; j++) cycle_step();
    check("b2b_returns_idle", int'(busy), 0);
    check("b2b_underrun", int'(underrun), 0);

    for (int r = 0; r < 5; r++) run_frame(r);

    // Reset while payload byte 5 is on s_data.
    pay_base = 8'h20; pay_step = 8'h01; drop_at = -1; pay_k = 0;
    start = 1'b1;
    for (int j = 0; j < 100 && pay_k != 6; j++) begin
      cycle_step();
      start = 1'b0;
    end
    check("midrst_reached_pay5", pay_k, 6);
    check("midrst_txctl_before", int'(smp_ctl), 1);
    rst_n = 1'b0;
    cycle_step();
    check("midrst_txctl_after", int'(smp_ctl), 0);
    check("midrst_busy_after", int'(busy), 0);
    check("midrst_s_ready_after", int'(s_ready), 0);
    rst_n = 1'b1;
    cycle_step();
    cycle_step();
    run_frame(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
